// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch: button synchronizers and debouncers, a RUN/STOP/LAP control
// FSM, a BCD time counter with lap capture, and active-low 7-segment decode.
module stopwatch_ctrl #(
  parameter int unsigned DebounceCount = 500000,
  parameter int unsigned MaxMinTens    = 5
) (
  input  logic       Clock,
  input  logic       Clr,
  input  logic       Tick,
  input  logic       StartStopBtn,
  input  logic       LapBtn,
  output logic [3:0] SecOnes,
  output logic [3:0] SecTens,
  output logic [3:0] MinOnes,
  output logic [3:0] MinTens,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic       Running,
  output logic       LapFrozen,
  output logic       Wrap
);

  localparam int unsigned CntW = (DebounceCount > 2) ? $clog2(DebounceCount) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCount - 1);
  localparam logic [3:0] MinTensMax = 4'(MaxMinTens);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2,
    ST_LAP  = 2'd3
  } state_t;

  state_t state;

  logic [1:0]      ss_sync;
  logic [1:0]      lap_sync;
  logic            ss_deb;
  logic            lap_deb;
  logic [CntW-1:0] ss_cnt;
  logic [CntW-1:0] lap_cnt;
  logic            ss_flip;
  logic            lap_flip;
  logic            start_ev;
  logic            lap_ev;
  logic            counting;
  logic            clear_time;
  logic            at_max;

  logic [3:0] lap_so;
  logic [3:0] lap_st;
  logic [3:0] lap_mo;
  logic [3:0] lap_mt;
  logic [3:0] disp_so;
  logic [3:0] disp_st;
  logic [3:0] disp_mo;
  logic [3:0] disp_mt;

  // Two-flop synchronizers for both raw buttons
  always_ff @(posedge Clock or posedge Clr) begin
    if (Clr) begin
      ss_sync  <= 2'b00;
      lap_sync <= 2'b00;
    end else begin
      ss_sync  <= {ss_sync[0], StartStopBtn};
      lap_sync <= {lap_sync[0], LapBtn};
    end
  end

  // A flip happens on the DebounceCount-th consecutive mismatching cycle
  assign ss_flip  = (ss_sync[1] != ss_deb) && (ss_cnt == CntLast);
  assign lap_flip = (lap_sync[1] != lap_deb) && (lap_cnt == CntLast);

  // Start/Stop debouncer: count mismatch run, flip level when it is long enough
  always_ff @(posedge Clock or posedge Clr) begin
    if (Clr) begin
      ss_deb <= 1'b0;
      ss_cnt <= '0;
    end else if (ss_sync[1] != ss_deb) begin
      if (ss_flip) begin
        ss_deb <= ~ss_deb;
        ss_cnt <= '0;
      end else begin
        ss_cnt <= ss_cnt + CntW'(1);
      end
    end else begin
      ss_cnt <= '0;
    end
  end

  // Lap debouncer, same scheme as Start/Stop
  always_ff @(posedge Clock or posedge Clr) begin
    if (Clr) begin
      lap_deb <= 1'b0;
      lap_cnt <= '0;
    end else if (lap_sync[1] != lap_deb) begin
      if (lap_flip) begin
        lap_deb <= ~lap_deb;
        lap_cnt <= '0;
      end else begin
        lap_cnt <= lap_cnt + CntW'(1);
      end
    end else begin
      lap_cnt <= '0;
    end
  end

  // Press events are the rising flips; Start beats a same-cycle Lap
  assign start_ev   = ss_flip && !ss_deb;
  assign lap_ev     = lap_flip && !lap_deb && !start_ev;
  assign counting   = Tick && ((state == ST_RUN) || (state == ST_LAP));
  assign clear_time = (state == ST_STOP) && lap_ev && !start_ev;
  assign at_max     = (SecOnes == 4'd9) && (SecTens == 4'd5) &&
                      (MinOnes == 4'd9) && (MinTens == MinTensMax);

  // Control FSM with registered status flags and lap capture
  always_ff @(posedge Clock or posedge Clr) begin
    if (Clr) begin
      state     <= ST_IDLE;
      Running   <= 1'b0;
      LapFrozen <= 1'b0;
      lap_so    <= 4'd0;
      lap_st    <= 4'd0;
      lap_mo    <= 4'd0;
      lap_mt    <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ev) begin
            state   <= ST_RUN;
            Running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (start_ev) begin
            state   <= ST_STOP;
            Running <= 1'b0;
          end else if (lap_ev) begin
            state     <= ST_LAP;
            LapFrozen <= 1'b1;
            lap_so    <= SecOnes;
            lap_st    <= SecTens;
            lap_mo    <= MinOnes;
            lap_mt    <= MinTens;
          end
        end
        ST_LAP: begin
          if (start_ev) begin
            state     <= ST_STOP;
            Running   <= 1'b0;
            LapFrozen <= 1'b0;
          end else if (lap_ev) begin
            state     <= ST_RUN;
            LapFrozen <= 1'b0;
          end
        end
        ST_STOP: begin
          if (start_ev) begin
            state   <= ST_RUN;
            Running <= 1'b1;
          end else if (lap_ev) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          Running   <= 1'b0;
          LapFrozen <= 1'b0;
        end
      endcase
    end
  end

  // BCD time counter with carry chain; a STOP->IDLE clear overrides counting
  always_ff @(posedge Clock or posedge Clr) begin
    if (Clr) begin
      SecOnes <= 4'd0;
      SecTens <= 4'd0;
      MinOnes <= 4'd0;
      MinTens <= 4'd0;
      Wrap    <= 1'b0;
    end else begin
      Wrap <= counting && at_max && !clear_time;
      if (clear_time) begin
        SecOnes <= 4'd0;
        SecTens <= 4'd0;
        MinOnes <= 4'd0;
        MinTens <= 4'd0;
      end else if (counting) begin
        if (SecOnes == 4'd9) begin
          SecOnes <= 4'd0;
          if (SecTens == 4'd5) begin
            SecTens <= 4'd0;
            if (MinOnes == 4'd9) begin
              MinOnes <= 4'd0;
              if (MinTens == MinTensMax) begin
                MinTens <= 4'd0;
              end else begin
                MinTens <= MinTens + 4'd1;
              end
            end else begin
              MinOnes <= MinOnes + 4'd1;
            end
          end else begin
            SecTens <= SecTens + 4'd1;
          end
        end else begin
          SecOnes <= SecOnes + 4'd1;
        end
      end
    end
  end

  // Display source: frozen lap value in LAP, live time otherwise
  always_comb begin
    disp_so = SecOnes;
    disp_st = SecTens;
    disp_mo = MinOnes;
    disp_mt = MinTens;
    if (state == ST_LAP) begin
      disp_so = lap_so;
      disp_st = lap_st;
      disp_mo = lap_mo;
      disp_mt = lap_mt;
    end
  end

  // Active-low {g,f,e,d,c,b,a} decode; non-BCD codes blank
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign HEX0 = seg7(disp_so);
  assign HEX1 = seg7(disp_st);
  assign HEX2 = seg7(disp_mo);
  assign HEX3 = seg7(disp_mt);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized and directed bench for stopwatch_ctrl against a seconds-based model.
module tb_stopwatch_ctrl;

  localparam int N     = 4;
  localparam int MAXMT = 5;
  localparam int TOTAL = (MAXMT + 1) * 600;
  localparam int HD    = N + 2;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;
  localparam int M_LAP  = 3;

  logic       Clock;
  logic       Clr;
  logic       Tick;
  logic       StartStopBtn;
  logic       LapBtn;
  logic [3:0] SecOnes, SecTens, MinOnes, MinTens;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;
  logic       Running, LapFrozen, Wrap;

  int n_vec;
  int n_err;

  // Reference model state: whole seconds, lap seconds, mode, raw button history
  int mode;
  int secs;
  int lap_secs;
  bit exp_wrap;
  bit ss_hist [HD];
  bit lp_hist [HD];
  bit ss_lvl;
  bit lp_lvl;
  logic [6:0] seg_tab [10];

  stopwatch_ctrl #(.DebounceCount(N), .MaxMinTens(MAXMT)) dut (
    .Clock(Clock), .Clr(Clr), .Tick(Tick),
    .StartStopBtn(StartStopBtn), .LapBtn(LapBtn),
    .SecOnes(SecOnes), .SecTens(SecTens), .MinOnes(MinOnes), .MinTens(MinTens),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .Running(Running), .LapFrozen(LapFrozen), .Wrap(Wrap)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd_of(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic logic [27:0] hex_of(input int s);
    return {seg_tab[s / 600], seg_tab[(s / 60) % 10], seg_tab[(s % 60) / 10], seg_tab[s % 10]};
  endfunction

  task automatic model_reset();
    mode     = M_IDLE;
    secs     = 0;
    lap_secs = 0;
    exp_wrap = 1'b0;
    ss_lvl   = 1'b0;
    lp_lvl   = 1'b0;
    for (int i = 0; i < HD; i++) begin
      ss_hist[i] = 1'b0;
      lp_hist[i] = 1'b0;
    end
  endtask

  // A level is accepted once the N most recent synchronized samples all disagree with it
  task automatic model_step(input bit tk, input bit ss, input bit lp);
    bit ss_ev, lp_ev, all_ss, all_lp, cnt;
    int nsecs;
    for (int i = HD - 1; i > 0; i--) begin
      ss_hist[i] = ss_hist[i-1];
      lp_hist[i] = lp_hist[i-1];
    end
    ss_hist[0] = ss;
    lp_hist[0] = lp;
    all_ss = 1'b1;
    all_lp = 1'b1;
    for (int i = 2; i < HD; i++) begin
      if (ss_hist[i] == ss_lvl) all_ss = 1'b0;
      if (lp_hist[i] == lp_lvl) all_lp = 1'b0;
    end
    ss_ev = 1'b0;
    lp_ev = 1'b0;
    if (all_ss) begin
      ss_lvl = ~ss_lvl;
      ss_ev  = ss_lvl;
    end
    if (all_lp) begin
      lp_lvl = ~lp_lvl;
      lp_ev  = lp_lvl;
    end
    if (ss_ev) lp_ev = 1'b0;

    cnt      = tk && (mode == M_RUN || mode == M_LAP);
    exp_wrap = cnt && (secs == TOTAL - 1);
    nsecs    = cnt ? (secs + 1) % TOTAL : secs;
    case (mode)
      M_IDLE: if (ss_ev) mode = M_RUN;
      M_RUN: begin
        if (ss_ev) mode = M_STOP;
        else if (lp_ev) begin
          mode     = M_LAP;
          lap_secs = secs;
        end
      end
      M_LAP: begin
        if (ss_ev) mode = M_STOP;
        else if (lp_ev) mode = M_RUN;
      end
      default: begin
        if (ss_ev) mode = M_RUN;
        else if (lp_ev) begin
          mode  = M_IDLE;
          nsecs = 0;
        end
      end
    endcase
    secs = nsecs;
  endtask

  task automatic compare_all();
    check_eq("time", 32'({MinTens, MinOnes, SecTens, SecOnes}), 32'(bcd_of(secs)));
    check_eq("hex", 32'({HEX3, HEX2, HEX1, HEX0}),
             32'(hex_of((mode == M_LAP) ? lap_secs : secs)));
    check_eq("flags", 32'({Running, LapFrozen, Wrap}),
             32'({(mode == M_RUN || mode == M_LAP), (mode == M_LAP), exp_wrap}));
  endtask

  // One clock: drive at negedge, step the model at posedge, sample at next negedge
  task automatic cyc(input bit tk, input bit ss, input bit lp);
    Tick         = tk;
    StartStopBtn = ss;
    LapBtn       = lp;
    @(posedge Clock);
    model_step(tk, ss, lp);
    @(negedge Clock);
    compare_all();
  endtask

  // Clean press: hold long enough to register, then release long enough to settle
  task automatic press(input bit ss, input bit lp, input bit tk);
    repeat (N + 2) cyc(tk, ss, lp);
    repeat (N + 3) cyc(tk, 1'b0, 1'b0);
  endtask

  initial begin
    bit rs, rl;
    n_vec = 0;
    n_err = 0;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    Clr = 1'b1;
    Tick = 1'b0;
    StartStopBtn = 1'b0;
    LapBtn = 1'b0;
    model_reset();
    repeat (3) @(negedge Clock);
    compare_all();
    check_eq("rst_hex", 32'({HEX3, HEX2, HEX1, HEX0}), 32'({4{7'h40}}));
    Clr = 1'b0;

    // Ticks in IDLE do not count
    repeat (5) cyc(1'b1, 1'b0, 1'b0);
    check_eq("idle_time", 32'({MinTens, MinOnes, SecTens, SecOnes}), 32'h0000);

    // Bouncing Start shorter than the debounce window is rejected
    repeat (4) begin
      repeat (3) cyc(1'b0, 1'b1, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
    end
    check_eq("bounce_run", 32'(Running), 32'(0));

    // Start: Running rises at edge 2+N of the press
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      check_eq("run_lat", 32'(Running), 32'(i >= 6));
    end
    repeat (75) cyc(1'b1, 1'b0, 1'b0);
    check_eq("t115_hex1", 32'(HEX1), 32'h79);
    check_eq("t115_hex0", 32'(HEX0), 32'h12);

    // Stop, clear, restart and run to 00:42
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    check_eq("clr_time", 32'({MinTens, MinOnes, SecTens, SecOnes}), 32'h0000);
    press(1'b1, 1'b0, 1'b0);
    repeat (42) cyc(1'b1, 1'b0, 1'b0);

    // Lap freezes 00:42 while live time keeps going
    press(1'b0, 1'b1, 1'b0);
    repeat (10) cyc(1'b1, 1'b0, 1'b0);
    check_eq("lap_frozen", 32'(LapFrozen), 32'(1));
    check_eq("lap_hex1", 32'(HEX1), 32'h19);
    check_eq("lap_hex0", 32'(HEX0), 32'h24);
    check_eq("lap_live", 32'({SecTens, SecOnes}), 32'h52);
    press(1'b0, 1'b1, 1'b0);
    check_eq("unlap_hex1", 32'(HEX1), 32'h12);
    check_eq("unlap_hex0", 32'(HEX0), 32'h24);

    // Full wrap from 00:00
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    repeat (3599) cyc(1'b1, 1'b0, 1'b0);
    check_eq("max_time", 32'({MinTens, MinOnes, SecTens, SecOnes}), 32'h5959);
    check_eq("pre_wrap", 32'(Wrap), 32'(0));
    cyc(1'b1, 1'b0, 1'b0);
    check_eq("wrap_time", 32'({MinTens, MinOnes, SecTens, SecOnes}), 32'h0000);
    check_eq("wrap_pulse", 32'(Wrap), 32'(1));
    cyc(1'b0, 1'b0, 1'b0);
    check_eq("wrap_end", 32'(Wrap), 32'(0));

    // Simultaneous Start+Lap in RUN goes to STOP; Lap+Tick in STOP clears
    repeat (7) cyc(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    check_eq("both_flags", 32'({Running, LapFrozen}), 32'(0));
    check_eq("both_time", 32'({MinTens, MinOnes, SecTens, SecOnes}), 32'h0007);
    press(1'b0, 1'b1, 1'b1);
    check_eq("stop_clr", 32'({MinTens, MinOnes, SecTens, SecOnes}), 32'h0000);

    // Asynchronous reset between clock edges
    press(1'b1, 1'b0, 1'b0);
    repeat (20) cyc(1'b1, 1'b0, 1'b0);
    #2 Clr = 1'b1;
    #1 model_reset();
    compare_all();
    check_eq("areset_hex", 32'({HEX3, HEX2, HEX1, HEX0}), 32'({4{7'h40}}));
    @(negedge Clock);
    Clr = 1'b0;

    // Random button activity with bounces and random ticks
    rs = 1'b0;
    rl = 1'b0;
    repeat (4000) begin
      if ($urandom_range(5, 0) == 0) rs = ~rs;
      if ($urandom_range(7, 0) == 0) rl = ~rl;
      cyc(1'($urandom_range(1, 0)), rs, rl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
